// File: rtl/adder_operand_sequencer.sv
// Serial operand loader and result register for an N-bit ripple adder.
// Operands arrive on LOAD rising edges; results leave over a valid/ready handshake.
module adder_operand_sequencer #(
  parameter int N       = 3,
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [N-1:0]       DATA_IN,
  input  logic               LOAD,
  input  logic               CLEAR,
  input  logic               ACCUMULATE,
  output logic [N-1:0]       OPERAND1,
  output logic [N-1:0]       OPERAND2,
  input  logic [N-1:0]       SUM,
  input  logic               CARRY,
  output logic [N-1:0]       RESULT,
  output logic               RESULT_CARRY,
  output logic               RESULT_ZERO,
  output logic               RESULT_VALID,
  input  logic               RESULT_READY,
  output logic [COUNT_W-1:0] OP_COUNT,
  output logic [1:0]         STATE
);

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t             state_q;
  logic               load_prev_q;
  logic [N-1:0]       op1_q;
  logic [N-1:0]       op2_q;
  logic [N-1:0]       result_q;
  logic               carry_q;
  logic               zero_q;
  logic               valid_q;
  logic [COUNT_W-1:0] count_q;
  logic               load_edge;

  assign load_edge = LOAD & ~load_prev_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= WAIT_A;
      load_prev_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      valid_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      load_prev_q <= LOAD;
      if (CLEAR) begin
        // Abort: any edge seen this cycle is swallowed, the counter survives.
        state_q  <= WAIT_A;
        op1_q    <= '0;
        op2_q    <= '0;
        result_q <= '0;
        carry_q  <= 1'b0;
        zero_q   <= 1'b1;
        valid_q  <= 1'b0;
      end else begin
        unique case (state_q)
          WAIT_A: begin
            if (load_edge) begin
              op1_q   <= DATA_IN;
              state_q <= WAIT_B;
            end
          end
          WAIT_B: begin
            if (load_edge) begin
              op2_q   <= DATA_IN;
              state_q <= CAPTURE;
            end
          end
          CAPTURE: begin
            // Operands have been stable for a full cycle, so the adder has settled.
            result_q <= SUM;
            carry_q  <= CARRY;
            zero_q   <= (SUM == '0);
            valid_q  <= 1'b1;
            count_q  <= count_q + 1'b1;
            state_q  <= HOLD;
          end
          HOLD: begin
            if (RESULT_READY) begin
              valid_q <= 1'b0;
              if (ACCUMULATE) begin
                op1_q   <= result_q;
                state_q <= WAIT_B;
              end else if (load_edge) begin
                op1_q   <= DATA_IN;
                state_q <= WAIT_B;
              end else begin
                state_q <= WAIT_A;
              end
            end
          end
          default: state_q <= WAIT_A;
        endcase
      end
    end
  end

  assign OPERAND1     = op1_q;
  assign OPERAND2     = op2_q;
  assign RESULT       = result_q;
  assign RESULT_CARRY = carry_q;
  assign RESULT_ZERO  = zero_q;
  assign RESULT_VALID = valid_q;
  assign OP_COUNT     = count_q;
  assign STATE        = state_q;

endmodule

// File: doc/adder_operand_sequencer.md
# adder_operand_sequencer

Sequential front/back end for the N-bit ripple adder. It captures two operands serially from one shared input bus (board switches) on LOAD rising edges and drives them onto the adder inputs. It then registers the adder's sum and carry with status flags and presents the result to the display stage over a valid/ready handshake. An accumulate mode chains results back as operand 1.

## Interface
- N, 3, operand/result width; equals the adder's N
- COUNT_W, 8, width of completed-operation counter
- CLK  in  1  single clock, all state on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- DATA_IN  in  N  operand value to load
- LOAD  in  1  level input; operand accepted on rising edge only (1 now, 0 previous cycle)
- CLEAR  in  1  synchronous abort/clear, highest priority after reset
- ACCUMULATE  in  1  when 1, a consumed result becomes the next OPERAND1
- OPERAND1  out  N  to adder INPUT1
- OPERAND2  out  N  to adder INPUT2
- SUM  in  N  from adder ANSWER
- CARRY  in  1  from adder carry out
- RESULT  out  N  registered sum
- RESULT_CARRY  out  1  registered carry
- RESULT_ZERO  out  1  1 when registered sum == 0; carry ignored
- RESULT_VALID  out  1  result available
- RESULT_READY  in  1  consumer accepts result
- OP_COUNT  out  COUNT_W  completed operations, wraps modulo 2^COUNT_W
- STATE  out  2  current state code, for LEDs

## Operation
- States: WAIT_A=0, WAIT_B=1, CAPTURE=2, HOLD=3.
- Internal LOAD_PREV register; edge = LOAD & ~LOAD_PREV.
- WAIT_A: on edge, OPERAND1<=DATA_IN, go to WAIT_B.
- WAIT_B: on edge, OPERAND2<=DATA_IN, go to CAPTURE.
- CAPTURE, unconditionally:
  - RESULT<=SUM, RESULT_CARRY<=CARRY, RESULT_ZERO<=(SUM==0);
  - RESULT_VALID<=1, OP_COUNT<=OP_COUNT+1;
  - go to HOLD. LOAD edges are ignored here.
- HOLD: RESULT, flags and operands stay stable while RESULT_READY=0. When RESULT_READY=1, RESULT_VALID<=0 and:
  - ACCUMULATE=1: OPERAND1<=RESULT, go to WAIT_B. A same-cycle edge is ignored.
  - ACCUMULATE=0 with edge in the same cycle: OPERAND1<=DATA_IN, go to WAIT_B.
  - otherwise: go to WAIT_A.
- HOLD edges with RESULT_READY=0 are discarded; they are not queued.
- CLEAR=1 in any state:
  - STATE<=WAIT_A;
  - OPERAND1, OPERAND2, RESULT, RESULT_CARRY <= 0;
  - RESULT_ZERO<=1, RESULT_VALID<=0;
  - OP_COUNT is kept; LOAD_PREV<=LOAD; no edge is acted on that cycle.
- Sum is modulo 2^N. Overflow is reported only through RESULT_CARRY.
- OP_COUNT wraps from all-ones to 0 without a flag.

## Timing
- Reset (RESET_N=0, asynchronous):
  - STATE=WAIT_A;
  - OPERAND1=OPERAND2=0, RESULT=0, RESULT_CARRY=0, RESULT_ZERO=1;
  - RESULT_VALID=0, OP_COUNT=0, LOAD_PREV=0.
- Reset release is synchronous to CLK. A LOAD held high through reset produces one edge on the first active cycle.
- Operand load: edge sampled at clock edge k makes OPERAND visible after edge k.
- Result: second operand loaded at edge k, CAPTURE during cycle k..k+1, so RESULT/RESULT_VALID are valid after edge k+1.
  - The adder gets one full cycle of settling.
  - Minimum edge-to-valid latency is 2 clocks.
- Handshake: transfer occurs on an edge where RESULT_VALID=1 and RESULT_READY=1. RESULT_VALID drops after that edge.
- RESULT_READY is ignored while RESULT_VALID=0.
- Back-to-back chaining:
  - HOLD→WAIT_B in one cycle, so a new result can be valid 3 clocks after the previous transfer.
  - In accumulate mode this needs one LOAD edge per step.
- Reset or CLEAR mid-operation abandons the operation; OP_COUNT is not incremented.

## Test plan
- N=3: reset, load 3 then 2, hold READY=1 → RESULT=5, CARRY=0, ZERO=0, VALID high exactly 2 clocks after second edge for 1 cycle, OP_COUNT=1.
- Load 7 then 1 → RESULT=0, CARRY=1, ZERO=1. Hold LOAD high 5 cycles during WAIT_A → only one operand accepted, state advances to WAIT_B only.
- Back-pressure: READY=0 for 10 cycles after result 6 (4+2), with LOAD edges in HOLD → RESULT stays 6, VALID stays 1, operands unchanged, edges discarded. Then READY=1 → VALID=0, state WAIT_A.
- Accumulate: ACCUMULATE=1, load 1 and 2, then edges with DATA_IN=3, 3 → successive results 3, 6, 1 with carry 1; OPERAND1 follows the previous result.
- CLEAR in WAIT_B after loading 5 → state WAIT_A, operands 0, VALID 0, OP_COUNT unchanged. Assert RESET_N=0 mid-CAPTURE → all outputs at reset values immediately, without a clock edge.
- COUNT_W=2: complete 5 operations → OP_COUNT sequence 1, 2, 3, 0, 1.
